// File: rtl/pmu_budget_regulator.sv
// Per-core bandwidth regulator: each core gets an access budget per period
// and is throttled until the next period boundary once it is exhausted.
// Ports:
//   clk_i, rst_ni          clock, async active-low reset
//   period_i               regulation period in cycles (0 = disabled)
//   budget_i               per-core budget, COUNTER_WIDTH bits each (0 = free)
//   req_valid_i/ready_o    upstream handshake per core
//   req_valid_o/ready_i    downstream handshake per core
//   throttle_o             core is in THROTTLED
//   intr_o                 one-cycle pulse on entry to THROTTLED
//   period_start_o         one-cycle pulse after each period boundary
//   remaining_o            remaining budget per core
module pmu_budget_regulator #(
   parameter int NUM_CORE      = 4,
   parameter int COUNTER_WIDTH = 32,
   parameter int TIMER_WIDTH   = 64
) (
   input  logic                              clk_i,
   input  logic                              rst_ni,
   input  logic [TIMER_WIDTH-1:0]            period_i,
   input  logic [NUM_CORE*COUNTER_WIDTH-1:0] budget_i,
   input  logic [NUM_CORE-1:0]               req_valid_i,
   output logic [NUM_CORE-1:0]               req_ready_o,
   output logic [NUM_CORE-1:0]               req_valid_o,
   input  logic [NUM_CORE-1:0]               req_ready_i,
   output logic [NUM_CORE-1:0]               throttle_o,
   output logic [NUM_CORE-1:0]               intr_o,
   output logic                              period_start_o,
   output logic [NUM_CORE*COUNTER_WIDTH-1:0] remaining_o
);

   localparam int CW = COUNTER_WIDTH;

   typedef enum logic {
      ACTIVE    = 1'b0,
      THROTTLED = 1'b1
   } state_e;

   logic [TIMER_WIDTH-1:0]   timer_q, timer_d;
   logic [TIMER_WIDTH-1:0]   period_q, period_d;
   logic [NUM_CORE*CW-1:0]   budget_q, budget_d;
   logic [NUM_CORE*CW-1:0]   remaining_q, remaining_d;
   state_e                   state_q [NUM_CORE];
   state_e                   state_d [NUM_CORE];
   logic [NUM_CORE-1:0]      pend_q, pend_d;
   logic [NUM_CORE-1:0]      intr_q, intr_d;
   logic                     start_q, start_d;
   logic [NUM_CORE-1:0]      pass;
   logic [NUM_CORE-1:0]      hs;
   logic                     enabled;
   logic                     boundary;
   logic                     reload;
   logic [CW-1:0]            rem_c;

   assign enabled  = (period_q != '0);
   assign boundary = enabled && (timer_q == period_q - TIMER_WIDTH'(1));
   // Disabled: shadows track inputs every cycle, so the first enabled
   // cycle already starts a fresh period with full budgets.
   assign reload   = !enabled || boundary;

   // A pending (offered but not yet accepted) valid always passes so the
   // downstream never sees a withdrawn request.
   always_comb begin
      for (int c = 0; c < NUM_CORE; c++) begin
         pass[c] = (state_q[c] == ACTIVE) || pend_q[c];
      end
   end

   assign req_valid_o = req_valid_i & pass;
   assign req_ready_o = req_ready_i & pass;
   assign hs          = req_valid_o & req_ready_i;

   always_comb begin
      timer_d     = timer_q + TIMER_WIDTH'(1);
      period_d    = period_q;
      budget_d    = budget_q;
      remaining_d = remaining_q;
      start_d     = 1'b0;
      intr_d      = '0;
      pend_d      = req_valid_o & ~req_ready_i;
      rem_c       = '0;
      for (int c = 0; c < NUM_CORE; c++) begin
         state_d[c] = state_q[c];
      end

      if (reload) begin
         // Boundary wins over a same-cycle exhaustion.
         timer_d     = '0;
         period_d    = period_i;
         budget_d    = budget_i;
         remaining_d = budget_i;
         start_d     = boundary;
         for (int c = 0; c < NUM_CORE; c++) begin
            state_d[c] = ACTIVE;
         end
      end else begin
         for (int c = 0; c < NUM_CORE; c++) begin
            rem_c = remaining_q[c*CW +: CW];
            // rem_c != 0 also blocks counting of a pending completion
            // that lands while throttled.
            if (state_q[c] == ACTIVE && hs[c] &&
                budget_q[c*CW +: CW] != '0 && rem_c != '0) begin
               remaining_d[c*CW +: CW] = rem_c - CW'(1);
               if (rem_c == CW'(1)) begin
                  state_d[c] = THROTTLED;
                  intr_d[c]  = 1'b1;
               end
            end
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         timer_q     <= '0;
         period_q    <= '0;
         budget_q    <= '0;
         remaining_q <= '0;
         pend_q      <= '0;
         intr_q      <= '0;
         start_q     <= 1'b0;
         for (int c = 0; c < NUM_CORE; c++) begin
            state_q[c] <= ACTIVE;
         end
      end else begin
         timer_q     <= timer_d;
         period_q    <= period_d;
         budget_q    <= budget_d;
         remaining_q <= remaining_d;
         pend_q      <= pend_d;
         intr_q      <= intr_d;
         start_q     <= start_d;
         for (int c = 0; c < NUM_CORE; c++) begin
            state_q[c] <= state_d[c];
         end
      end
   end

   always_comb begin
      for (int c = 0; c < NUM_CORE; c++) begin
         throttle_o[c] = (state_q[c] == THROTTLED);
      end
   end

   assign intr_o         = intr_q;
   assign period_start_o = start_q;
   assign remaining_o    = remaining_q;

endmodule

// File: tb/tb_pmu_budget_regulator.sv
// Testbench for pmu_budget_regulator: directed scenarios plus randomized
// traffic compared against a budget-usage reference model.
module tb_pmu_budget_regulator;

   localparam int NC = 4;
   localparam int CW = 32;
   localparam int TW = 64;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [TW-1:0]    period;
   logic [NC*CW-1:0] budget;
   logic [NC-1:0]    vi, ro, vo, ri, thr, intr;
   logic             ps;
   logic [NC*CW-1:0] rem;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: per-core count of handshakes charged this period.
   int m_timer, m_per;
   int m_bud  [NC];
   int m_used [NC];
   bit m_pend [NC];
   bit m_intr [NC];
   bit m_ps;

   always #5 clk = ~clk;

   pmu_budget_regulator dut (
      .clk_i          (clk),
      .rst_ni         (rst_n),
      .period_i       (period),
      .budget_i       (budget),
      .req_valid_i    (vi),
      .req_ready_o    (ro),
      .req_valid_o    (vo),
      .req_ready_i    (ri),
      .throttle_o     (thr),
      .intr_o         (intr),
      .period_start_o (ps),
      .remaining_o    (rem)
   );

   function automatic bit m_thr(int c);
      return (m_bud[c] != 0) && (m_used[c] >= m_bud[c]);
   endfunction

   function automatic bit m_pass(int c);
      return !m_thr(c) || m_pend[c];
   endfunction

   task automatic model_reset();
      m_timer = 0;
      m_per   = 0;
      m_ps    = 0;
      for (int c = 0; c < NC; c++) begin
         m_bud[c]  = 0;
         m_used[c] = 0;
         m_pend[c] = 0;
         m_intr[c] = 0;
      end
   endtask

   task automatic tick();
      int nt, np;
      int nb [NC];
      int nu [NC];
      bit npd [NC];
      bit ni [NC];
      bit en, bnd, v, h;
      en  = (m_per != 0);
      bnd = en && (m_timer == m_per - 1);
      for (int c = 0; c < NC; c++) begin
         v      = vi[c] && m_pass(c);
         h      = v && ri[c];
         npd[c] = v && !ri[c];
         ni[c]  = 0;
         if (!en || bnd) begin
            nu[c] = 0;
            nb[c] = int'(budget[c*CW +: CW]);
         end else begin
            nb[c] = m_bud[c];
            nu[c] = m_used[c];
            if (h && m_bud[c] != 0 && m_used[c] < m_bud[c]) begin
               nu[c] = nu[c] + 1;
               ni[c] = (nu[c] == m_bud[c]);
            end
         end
      end
      nt = (!en || bnd) ? 0 : m_timer + 1;
      np = (!en || bnd) ? int'(period) : m_per;
      @(posedge clk);
      #1;
      m_timer = nt;
      m_per   = np;
      m_ps    = bnd;
      for (int c = 0; c < NC; c++) begin
         m_bud[c]  = nb[c];
         m_used[c] = nu[c];
         m_pend[c] = npd[c];
         m_intr[c] = ni[c];
      end
   endtask

   task automatic do_reset();
      rst_n  = 1'b0;
      vi     = '0;
      ri     = '0;
      period = '0;
      budget = '0;
      model_reset();
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n  = 1'b0;
      vi     = '0;
      ri     = '0;
      period = TW'(20);
      budget = '1;
      #2;
      n_tests++;
      if (thr !== '0) begin
         n_fail++;
         $display("FAIL reset_throttle got=%b exp=0", thr);
      end
      n_tests++;
      if (intr !== '0) begin
         n_fail++;
         $display("FAIL reset_intr got=%b exp=0", intr);
      end
      n_tests++;
      if (ps !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_period_start got=%b exp=0", ps);
      end
      n_tests++;
      if (rem !== '0) begin
         n_fail++;
         $display("FAIL reset_remaining got=%h exp=0", rem);
      end
   endtask

   task automatic test_passthrough();
      int cnt, bad;
      do_reset();
      budget[0 +: CW] = CW'(3);
      vi[0] = 1'b1;
      ri[0] = 1'b1;
      cnt = 0;
      bad = 0;
      for (int t = 0; t < 10; t++) begin
         #1;
         if (vo[0] && ri[0]) cnt++;
         if (thr[0] || intr[0]) bad++;
         tick();
      end
      n_tests++;
      if (cnt !== 10) begin
         n_fail++;
         $display("FAIL passthru_count got=%0d exp=10", cnt);
      end
      n_tests++;
      if (bad !== 0) begin
         n_fail++;
         $display("FAIL passthru_throttle_intr got=%0d exp=0", bad);
      end
   endtask

   task automatic test_exhaust();
      int hs, last, ic, icyc, leak, r_at, hs2, t;
      bit got;
      do_reset();
      period = TW'(20);
      budget[0 +: CW] = CW'(3);
      ri = '1;
      tick();
      vi[0] = 1'b1;
      hs = 0; last = -1; ic = 0; icyc = -1; leak = 0; got = 0; t = 0;
      while (!got && t < 40) begin
         #1;
         if (ps) begin
            got  = 1;
            r_at = int'(rem[0 +: CW]);
         end else begin
            if (vo[0] && ri[0]) begin
               hs++;
               last = t;
            end
            if (intr[0]) begin
               ic++;
               icyc = t;
            end
            if (hs >= 3 && t > last && ro[0]) leak++;
            tick();
            t++;
         end
      end
      n_tests++;
      if (!got) begin
         n_fail++;
         $display("FAIL exhaust_boundary_timeout got=none exp=period_start");
      end
      n_tests++;
      if (hs !== 3) begin
         n_fail++;
         $display("FAIL exhaust_count got=%0d exp=3", hs);
      end
      n_tests++;
      if (ic !== 1 || icyc !== last + 1) begin
         n_fail++;
         $display("FAIL exhaust_intr got=%0d@%0d exp=1@%0d", ic, icyc, last + 1);
      end
      n_tests++;
      if (leak !== 0) begin
         n_fail++;
         $display("FAIL exhaust_ready_gated got=%0d exp=0", leak);
      end
      n_tests++;
      if (r_at !== 3) begin
         n_fail++;
         $display("FAIL exhaust_refill got=%0d exp=3", r_at);
      end
      hs2 = 0;
      got = 0;
      for (int k = 0; k < 40 && !got; k++) begin
         if (k > 0) begin
            #1;
            if (ps) got = 1;
         end
         if (!got && vo[0] && ri[0]) hs2++;
         if (!got) tick();
      end
      n_tests++;
      if (hs2 !== 3 || !got) begin
         n_fail++;
         $display("FAIL exhaust_second_period got=%0d exp=3", hs2);
      end
   endtask

   task automatic test_pending();
      int leak, drop;
      bit got, done;
      do_reset();
      period = TW'(20);
      budget[0 +: CW] = CW'(1);
      ri = '1;
      tick();
      vi[0] = 1'b1;
      #1;
      n_tests++;
      if (!(vo[0] && ro[0])) begin
         n_fail++;
         $display("FAIL pend_first_hs got=%b%b exp=11", vo[0], ro[0]);
      end
      tick();
      vi[0] = 1'b0;
      tick();
      vi[0] = 1'b1;
      leak = 0;
      got  = 0;
      for (int k = 0; k < 40 && !got; k++) begin
         #1;
         if (ps) got = 1;
         else if (vo[0] || ro[0]) leak++;
         if (!got) tick();
      end
      n_tests++;
      if (leak !== 0 || !got) begin
         n_fail++;
         $display("FAIL pend_blocked got=%0d exp=0", leak);
      end

      do_reset();
      period = TW'(20);
      budget[0 +: CW] = CW'(1);
      tick();
      vi[0] = 1'b1;
      drop  = 0;
      for (int k = 0; k < 3; k++) begin
         #1;
         if (!vo[0]) drop++;
         tick();
      end
      ri[0] = 1'b1;
      #1;
      done = vo[0] && ro[0];
      tick();
      vi[0] = 1'b0;
      #1;
      n_tests++;
      if (drop !== 0 || !done) begin
         n_fail++;
         $display("FAIL pend_stall_hold got=%0d/%b exp=0/1", drop, done);
      end
      n_tests++;
      if (rem[0 +: CW] !== '0 || thr[0] !== 1'b1) begin
         n_fail++;
         $display("FAIL pend_after got=%0d/%b exp=0/1", rem[0 +: CW], thr[0]);
      end
   endtask

   task automatic test_collision();
      int hs;
      do_reset();
      period = TW'(20);
      budget[0 +: CW] = CW'(3);
      ri = '1;
      tick();
      repeat (17) tick();
      vi[0] = 1'b1;
      hs = 0;
      for (int k = 0; k < 3; k++) begin
         #1;
         if (vo[0] && ri[0]) hs++;
         tick();
      end
      vi[0] = 1'b0;
      #1;
      n_tests++;
      if (hs !== 3 || ps !== 1'b1) begin
         n_fail++;
         $display("FAIL collide_setup got=%0d/%b exp=3/1", hs, ps);
      end
      n_tests++;
      if (intr[0] !== 1'b0 || thr[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL collide_state got=%b/%b exp=0/0", intr[0], thr[0]);
      end
      n_tests++;
      if (rem[0 +: CW] !== CW'(3)) begin
         n_fail++;
         $display("FAIL collide_remaining got=%0d exp=3", rem[0 +: CW]);
      end
   endtask

   task automatic test_reconfig();
      int per, r_at, h1, t1;
      int h0 [2];
      bit t0;
      do_reset();
      period = TW'(20);
      budget[0 +: CW] = CW'(3);
      budget[CW +: CW] = CW'(0);
      ri = '1;
      tick();
      vi = 4'b0011;
      per = 0; r_at = -1; h1 = 0; t1 = 0; t0 = 0;
      h0[0] = 0;
      h0[1] = 0;
      for (int t = 0; t < 60 && per < 2; t++) begin
         if (t == 5) budget[0 +: CW] = CW'(5);
         #1;
         if (ps) begin
            per++;
            if (per == 1) r_at = int'(rem[0 +: CW]);
         end
         if (per < 2) begin
            if (vo[0] && ri[0]) h0[per]++;
            if (vo[1] && ri[1]) h1++;
            if (thr[1]) t1++;
            if (thr[0]) t0 = 1;
            tick();
         end
      end
      n_tests++;
      if (per !== 2 || h0[0] !== 3 || h0[1] !== 5) begin
         n_fail++;
         $display("FAIL reconfig_counts got=%0d/%0d/%0d exp=2/3/5", per, h0[0], h0[1]);
      end
      n_tests++;
      if (r_at !== 5) begin
         n_fail++;
         $display("FAIL reconfig_refill got=%0d exp=5", r_at);
      end
      n_tests++;
      if (t1 !== 0 || h1 !== 40 || !t0) begin
         n_fail++;
         $display("FAIL independence got=%0d/%0d/%b exp=0/40/1", t1, h1, t0);
      end
   endtask

   task automatic test_async_reset();
      int n;
      do_reset();
      period = TW'(20);
      budget[0 +: CW] = CW'(3);
      ri = '1;
      tick();
      vi[0] = 1'b1;
      repeat (7) tick();
      #1;
      n_tests++;
      if (thr[0] !== 1'b1) begin
         n_fail++;
         $display("FAIL areset_pre got=%b exp=1", thr[0]);
      end
      rst_n = 1'b0;
      #1;
      n_tests++;
      if (thr !== '0 || rem !== '0 || intr !== '0 || ps !== 1'b0) begin
         n_fail++;
         $display("FAIL areset_now got=%b/%h/%b/%b exp=0", thr, rem, intr, ps);
      end
      model_reset();
      vi = '0;
      #1;
      rst_n = 1'b1;
      n = 0;
      while (!ps && n < 40) begin
         tick();
         n++;
      end
      n_tests++;
      if (n !== 21) begin
         n_fail++;
         $display("FAIL areset_timer_restart got=%0d exp=21", n);
      end
   endtask

   task automatic test_random();
      logic [NC-1:0]    ev, er, et, ei;
      logic [NC*CW-1:0] erem;
      do_reset();
      for (int t = 0; t < 800; t++) begin
         if (t % 60 == 0) begin
            period = TW'($urandom_range(0, 6));
            for (int c = 0; c < NC; c++)
               budget[c*CW +: CW] = CW'($urandom_range(0, 3));
         end
         for (int c = 0; c < NC; c++) begin
            vi[c] = m_pend[c] ? 1'b1 : ($urandom_range(0, 9) < 7);
            ri[c] = ($urandom_range(0, 9) < 6);
         end
         #1;
         for (int c = 0; c < NC; c++) begin
            ev[c] = vi[c] && m_pass(c);
            er[c] = ri[c] && m_pass(c);
            et[c] = m_thr(c);
            ei[c] = m_intr[c];
            erem[c*CW +: CW] = CW'(m_bud[c] - m_used[c]);
         end
         n_tests++;
         if (vo !== ev || ro !== er) begin
            n_fail++;
            $display("FAIL rnd_gate t=%0d got=%b/%b exp=%b/%b", t, vo, ro, ev, er);
         end
         n_tests++;
         if (thr !== et || intr !== ei || ps !== m_ps) begin
            n_fail++;
            $display("FAIL rnd_status t=%0d got=%b/%b/%b exp=%b/%b/%b",
                     t, thr, intr, ps, et, ei, m_ps);
         end
         n_tests++;
         if (rem !== erem) begin
            n_fail++;
            $display("FAIL rnd_remaining t=%0d got=%h exp=%h", t, rem, erem);
         end
         tick();
      end
   endtask

   initial begin
      test_reset();
      test_passthrough();
      test_exhaust();
      test_pending();
      test_collision();
      test_reconfig();
      test_async_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
